encoder_pri_rr: RTL and testbench

- Parametrised, registered successor to the 8-to-3 encoder. It captures N request lines into a pending register and encodes one pending request per transaction into a W-bit index.
- Presents the index on a valid/ready output handshake and clears the request once it is accepted.
- Selection is fixed-priority (highest index wins) or round-robin, chosen by parameter.
- Sits between interrupt/event sources and a single downstream consumer.

---
 rtl/encoder_pri_rr.sv | 102 ++++++++++
 tb/tb_encoder_pri_rr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_pri_rr.sv
// Registered N-input request encoder with a valid/ready output.
// Pending requests are presented one at a time, either highest-index first or round-robin.
module encoder_pri_rr #(
  parameter  int N    = 8,
  parameter  int MODE = 0,
  localparam int W    = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [W-1:0] a,
  output logic         vld,
  input  logic         rdy,
  output logic [N-1:0] pend,
  output logic         ovr
);

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] a_q, a_d;
  logic         vld_q, vld_d;
  logic         ovr_q, ovr_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         acc;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [W-1:0] ptr_sel;
  logic [W-1:0] base;
  logic [W-1:0] rr_idx;
  logic [W-1:0] sel_idx;
  logic         sel_hit;

  assign acc  = vld_q & rdy;
  assign clr  = acc ? (N'(1) << a_q) : '0;
  assign cand = (pend_q & ~clr) | d;

  // An accept this cycle already demotes the accepted index for the same-edge reload.
  always_comb begin
    ptr_sel = ptr_q;
    if (acc) begin
      ptr_sel = (a_q == '0) ? W'(N - 1) : a_q - W'(1);
    end
  end

  // Fixed priority is the round-robin search with the start point pinned at N-1.
  assign base = (MODE == 0) ? W'(N - 1) : ptr_sel;

  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    rr_idx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (k <= int'(base)) begin
        rr_idx = base - W'(k);
      end else begin
        rr_idx = W'(N + int'(base) - k);
      end
      if (cand[rr_idx]) begin
        sel_idx = rr_idx;
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d = cand;
    ovr_d  = |(pend_q & ~clr & d);
    ptr_d  = ptr_sel;
    a_d    = a_q;
    vld_d  = vld_q;
    if (!vld_q || acc) begin
      if (sel_hit) begin
        a_d   = sel_idx;
        vld_d = 1'b1;
      end else begin
        vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      a_q    <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ptr_q  <= W'(N - 1);
    end else begin
      pend_q <= pend_d;
      a_q    <= a_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      ptr_q  <= ptr_d;
    end
  end

  assign a    = a_q;
  assign vld  = vld_q;
  assign pend = pend_q;
  assign ovr  = ovr_q;

endmodule

// File: tb/tb_encoder_pri_rr.sv
// Scoreboard bench: fixed-priority and round-robin instances share stimulus,
// each checked every cycle against a per-bit behavioural model.
module tb_encoder_pri_rr;
  localparam int N = 8;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] d;
  logic         rdy;
  logic [2:0]   a0, a1;
  logic         vld0, vld1, ovr0, ovr1;
  logic [N-1:0] pend0, pend1;

  encoder_pri_rr #(.N(N), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .d(d), .a(a0), .vld(vld0),
    .rdy(rdy), .pend(pend0), .ovr(ovr0)
  );

  encoder_pri_rr #(.N(N), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .d(d), .a(a1), .vld(vld1),
    .rdy(rdy), .pend(pend1), .ovr(ovr1)
  );

  typedef struct packed {
    logic         vld;
    logic [2:0]   a;
    logic [N-1:0] pend;
    logic         ovr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   log0[$];
  int   log1[$];
  int   ovr_cnt0 = 0;
  int   ovr_cnt1 = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  // Model state: pending flags, presented index, and the last accepted index
  bit   mp[2][N];
  bit   mv[2];
  int   ma[2];
  bit   mo[2];
  int   mlast[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_step(input int m, input logic [N-1:0] din, input logic r, input logic rv);
    exp_t e;
    bit   accepted;
    int   pick;
    if (!rv) begin
      for (int i = 0; i < N; i++) mp[m][i] = 1'b0;
      mv[m] = 1'b0; ma[m] = 0; mo[m] = 1'b0; mlast[m] = 0;
    end else begin
      accepted = mv[m] && r;
      if (accepted) begin
        mp[m][ma[m]] = 1'b0;
        mlast[m] = ma[m];
      end
      mo[m] = 1'b0;
      for (int i = 0; i < N; i++) if (mp[m][i] && din[i]) mo[m] = 1'b1;
      for (int i = 0; i < N; i++) if (din[i]) mp[m][i] = 1'b1;
      if (!mv[m] || accepted) begin
        pick = -1;
        if (m == 0) begin
          for (int i = N - 1; i >= 0; i--) if (pick < 0 && mp[m][i]) pick = i;
        end else begin
          for (int s = 1; s <= N; s++) begin
            if (pick < 0 && mp[m][(mlast[m] - s + N) % N]) pick = (mlast[m] - s + N) % N;
          end
        end
        if (pick >= 0) begin
          mv[m] = 1'b1;
          ma[m] = pick;
        end else begin
          mv[m] = 1'b0;
        end
      end
    end
    e.vld = mv[m];
    e.a   = 3'(ma[m]);
    e.ovr = mo[m];
    for (int i = 0; i < N; i++) e.pend[i] = mp[m][i];
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] din, input logic r, input logic rv);
    d     = din;
    rdy   = r;
    rst_n = rv;
    model_step(0, din, r, rv);
    model_step(1, din, r, rv);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input exp_t e, input logic v, input logic [2:0] av,
                           input logic [N-1:0] p, input logic o);
    chk({nm, "_vld"}, 32'(v), 32'(e.vld));
    chk({nm, "_a"}, 32'(av), 32'(e.a));
    chk({nm, "_pend"}, 32'(p), 32'(e.pend));
    chk({nm, "_ovr"}, 32'(o), 32'(e.ovr));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk_state("fp", e, vld0, a0, pend0, ovr0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk_state("rr", e, vld1, a1, pend1, ovr1);
    end
    if (rst_n && rdy && vld0) log0.push_back(int'(a0));
    if (rst_n && rdy && vld1) log1.push_back(int'(a1));
    if (ovr0) ovr_cnt0++;
    if (ovr1) ovr_cnt1++;
  end

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    ovr_cnt0 = 0;
    ovr_cnt1 = 0;
  endtask

  task automatic chk_seq(input string nm, input int m, input int exp_q[$]);
    int got_q[$];
    got_q = (m == 0) ? log0 : log1;
    chk({nm, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_%0d", nm, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
    end
  endtask

  initial begin : stim
    int e[$];
    logic [N-1:0] din;

    drive('0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b0);

    // Reset in the middle of a transaction, with requests present
    clear_logs();
    drive(8'hA4, 1'b0, 1'b1);
    drive(8'h00, 1'b1, 1'b1);
    drive(8'hFF, 1'b0, 1'b0);
    repeat (3) drive(8'h00, 1'b0, 1'b1);
    e = {7};
    chk_seq("fp_rst", 0, e);
    chk_seq("rr_rst", 1, e);

    // Several simultaneous requests drained with rdy high
    clear_logs();
    drive(8'hA4, 1'b1, 1'b1);
    repeat (4) drive(8'h00, 1'b1, 1'b1);
    e = {7, 5, 2};
    chk_seq("fp_prio", 0, e);
    chk_seq("rr_prio", 1, e);

    // Backpressure: presented index holds while a higher request waits
    drive('0, 1'b0, 1'b0);
    clear_logs();
    drive(8'h10, 1'b0, 1'b1);
    drive(8'h80, 1'b0, 1'b1);
    repeat (3) drive(8'h00, 1'b0, 1'b1);
    repeat (3) drive(8'h00, 1'b1, 1'b1);
    e = {4, 7};
    chk_seq("fp_bp", 0, e);
    chk_seq("rr_bp", 1, e);

    // Two requests held every cycle: fairness differs by policy
    drive('0, 1'b0, 1'b0);
    clear_logs();
    repeat (8) drive(8'h81, 1'b1, 1'b1);
    repeat (3) drive(8'h00, 1'b1, 1'b1);
    e = {7, 7, 7, 7, 7, 7, 7, 7, 0};
    chk_seq("fp_fair", 0, e);
    e = {7, 0, 7, 0, 7, 0, 7, 0, 7};
    chk_seq("rr_fair", 1, e);

    // Repeated request on an already-pending bit
    drive('0, 1'b0, 1'b0);
    clear_logs();
    drive(8'h08, 1'b0, 1'b1);
    drive(8'h08, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b1, 1'b1);
    repeat (2) drive(8'h00, 1'b0, 1'b1);
    e = {3};
    chk_seq("fp_ovr_acc", 0, e);
    chk("fp_ovr_cnt", 32'(ovr_cnt0), 32'd1);
    chk("rr_ovr_cnt", 32'(ovr_cnt1), 32'd1);

    // Request arriving on the bit being accepted re-pends it without overrun
    drive('0, 1'b0, 1'b0);
    clear_logs();
    drive(8'h08, 1'b0, 1'b1);
    drive(8'h08, 1'b1, 1'b1);
    drive(8'h00, 1'b1, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    e = {3, 3};
    chk_seq("fp_repend", 0, e);
    chk_seq("rr_repend", 1, e);
    chk("fp_repend_ovr", 32'(ovr_cnt0), 32'd0);

    // Randomised traffic with occasional resets
    drive('0, 1'b0, 1'b0);
    for (int c = 0; c < 1500; c++) begin
      din = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 9) == 0) din = N'($urandom);
      drive(din, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
    end
    repeat (10) drive('0, 1'b1, 1'b1);

    @(negedge clk);
    #1;
    chk("q_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
